// File: rtl/dmem_arb_pkg.sv
// Shared constants and grant selection for the data-memory arbiter.
// The DMEM_ARB_RR_EN build option is consumed by dmem_arbiter; this package is option-neutral.
package dmem_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OWN_P = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int CNT_W = 4;

    // On a tie, prefer_d selects D; a lone requester always wins.
    function automatic logic arb_pick(input logic a_p, input logic a_d, input logic prefer_d);
        logic w_pick;
        if (a_p && a_d) begin
            w_pick = prefer_d ? OWN_D : OWN_P;
        end else if (a_d) begin
            w_pick = OWN_D;
        end else begin
            w_pick = OWN_P;
        end
        return w_pick;
    endfunction

endpackage

// File: rtl/dmem_lat_counter.sv
// Loadable down-counter with zero flag; times the memory access window.
module dmem_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load on grant, count down while the access is in progress, stop at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != {CNT_W{1'b0}})) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/dmem_arbiter.sv
// Multi-cycle single-port data-memory arbiter between the MEM stage (P) and debug/loader (D).
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; default build is fixed P-first priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WORD    = 64,
    parameter int LATENCY = 2
) (
    input  logic            im_clk,
    input  logic            reset,
    input  logic            p_req,
    input  logic            p_we,
    input  logic [WORD-1:0] p_addr,
    input  logic [WORD-1:0] p_wdata,
    output logic [WORD-1:0] p_rdata,
    output logic            p_ack,
    output logic            p_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [WORD-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    output logic [WORD-1:0] d_rdata,
    output logic            d_ack,
    output logic            dm_en,
    output logic            dm_we,
    output logic [WORD-1:0] dm_addr,
    output logic [WORD-1:0] dm_wdata,
    input  logic [WORD-1:0] dm_rdata,
    output logic            busy,
    output logic            owner
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    logic [1:0]      r_state;
    logic            r_owner;
    logic            r_dm_en;
    logic            r_dm_we;
    logic [WORD-1:0] r_dm_addr;
    logic [WORD-1:0] r_dm_wdata;
    logic [WORD-1:0] r_p_rdata;
    logic [WORD-1:0] r_d_rdata;
    logic            r_p_ack;
    logic            r_d_ack;

    logic            w_any_req;
    logic            w_grant;
    logic            w_prefer_d;
    logic            w_win;
    logic            w_cnt_zero;
    logic            w_cmd_we;
    logic [WORD-1:0] w_cmd_addr;
    logic [WORD-1:0] w_cmd_wdata;

    assign w_any_req = p_req | d_req;
    assign w_grant   = (r_state == IDLE) && w_any_req;

`ifdef DMEM_ARB_RR_EN
    logic r_last_win;

    // Remember the previous winner so the other port takes the next tie.
    always_ff @(posedge im_clk or posedge reset) begin
        if (reset) begin
            r_last_win <= OWN_D;
        end else if (w_grant) begin
            r_last_win <= w_win;
        end else begin
            r_last_win <= r_last_win;
        end
    end

    assign w_prefer_d = (r_last_win == OWN_P);
`else
    assign w_prefer_d = 1'b0;
`endif

    assign w_win       = arb_pick(p_req, d_req, w_prefer_d);
    assign w_cmd_we    = (w_win == OWN_D) ? d_we    : p_we;
    assign w_cmd_addr  = (w_win == OWN_D) ? d_addr  : p_addr;
    assign w_cmd_wdata = (w_win == OWN_D) ? d_wdata : p_wdata;

    dmem_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .i_clk      (im_clk),
        .i_rst      (reset),
        .i_load     (w_grant),
        .i_load_val (LOAD_VAL),
        .i_dec      (r_state == BUSY),
        .o_zero     (w_cnt_zero)
    );

    // Grant, hold the memory command for LATENCY cycles, then return data and a one-cycle ack.
    always_ff @(posedge im_clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= OWN_P;
            r_dm_en    <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= {WORD{1'b0}};
            r_dm_wdata <= {WORD{1'b0}};
            r_p_rdata  <= {WORD{1'b0}};
            r_d_rdata  <= {WORD{1'b0}};
            r_p_ack    <= 1'b0;
            r_d_ack    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state    <= BUSY;
                        r_owner    <= w_win;
                        r_dm_en    <= 1'b1;
                        r_dm_we    <= w_cmd_we;
                        r_dm_addr  <= w_cmd_addr;
                        r_dm_wdata <= w_cmd_wdata;
                    end
                end
                BUSY: begin
                    if (w_cnt_zero) begin
                        r_state    <= DONE;
                        r_dm_en    <= 1'b0;
                        r_dm_we    <= 1'b0;
                        r_dm_addr  <= {WORD{1'b0}};
                        r_dm_wdata <= {WORD{1'b0}};
                        r_p_ack    <= (r_owner == OWN_P);
                        r_d_ack    <= (r_owner == OWN_D);
                        // Writes leave the requester's read-data register untouched.
                        if (!r_dm_we && (r_owner == OWN_P)) begin
                            r_p_rdata <= dm_rdata;
                        end
                        if (!r_dm_we && (r_owner == OWN_D)) begin
                            r_d_rdata <= dm_rdata;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_p_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign p_rdata  = r_p_rdata;
    assign d_rdata  = r_d_rdata;
    assign p_ack    = r_p_ack;
    assign d_ack    = r_d_ack;
    // Low during the ack cycle so the pipeline advances on that edge.
    assign p_stall  = p_req & ~r_p_ack;
    assign dm_en    = r_dm_en;
    assign dm_we    = r_dm_we;
    assign dm_addr  = r_dm_addr;
    assign dm_wdata = r_dm_wdata;
    assign busy     = (r_state != IDLE);
    assign owner    = r_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with an ack scoreboard; expectations follow DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         p_req, p_we, d_req, d_we;
    logic [W-1:0] p_addr, p_wdata, d_addr, d_wdata;
    logic [W-1:0] p_rdata, d_rdata, dm_addr, dm_wdata, dm_rdata;
    logic         p_ack, p_stall, d_ack, dm_en, dm_we, busy, owner;

    logic         u1_p_req, u1_p_we, u1_d_req, u1_d_we;
    logic [W-1:0] u1_p_addr, u1_p_wdata, u1_d_addr, u1_d_wdata;
    logic [W-1:0] u1_p_rdata, u1_d_rdata, u1_dm_addr, u1_dm_wdata, u1_dm_rdata;
    logic         u1_p_ack, u1_p_stall, u1_d_ack, u1_dm_en, u1_dm_we, u1_busy, u1_owner;

    logic [W-1:0] tb_mem [0:255];
    assign dm_rdata    = tb_mem[dm_addr[7:0]];
    assign u1_dm_rdata = tb_mem[u1_dm_addr[7:0]];

    dmem_arbiter #(.WORD(W), .LATENCY(2)) dut (
        .im_clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ack(p_ack), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .busy(busy), .owner(owner)
    );

    dmem_arbiter #(.WORD(W), .LATENCY(1)) dut_l1 (
        .im_clk(clk), .reset(reset),
        .p_req(u1_p_req), .p_we(u1_p_we), .p_addr(u1_p_addr), .p_wdata(u1_p_wdata),
        .p_rdata(u1_p_rdata), .p_ack(u1_p_ack), .p_stall(u1_p_stall),
        .d_req(u1_d_req), .d_we(u1_d_we), .d_addr(u1_d_addr), .d_wdata(u1_d_wdata),
        .d_rdata(u1_d_rdata), .d_ack(u1_d_ack),
        .dm_en(u1_dm_en), .dm_we(u1_dm_we), .dm_addr(u1_dm_addr), .dm_wdata(u1_dm_wdata),
        .dm_rdata(u1_dm_rdata), .busy(u1_busy), .owner(u1_owner)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;
    int n_pack   = 0;

    typedef struct {
        logic         port;
        logic [W-1:0] rdata;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t sbq1[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic got_ack(input int which, input logic port, input logic [W-1:0] rd);
        exp_t e;
        int   sz;
        sz = (which == 0) ? sbq.size() : sbq1.size();
        chk("sb_pending", W'(sz > 0), W'(1));
        if (sz > 0) begin
            if (which == 0) e = sbq.pop_front();
            else            e = sbq1.pop_front();
            chk("ack_port",  W'(port), W'(e.port));
            chk("ack_cycle", W'(cyc),  W'(e.cyc));
            chk("ack_rdata", rd,       e.rdata);
        end
    endtask

    // Scoreboard monitor: every ack is matched against the next expected completion.
    always @(negedge clk) begin
        if (!reset) begin
            if (p_ack) begin
                n_pack++;
                got_ack(0, 1'b0, p_rdata);
            end
            if (d_ack)    got_ack(0, 1'b1, d_rdata);
            if (u1_p_ack) got_ack(1, 1'b0, u1_p_rdata);
            if (u1_d_ack) got_ack(1, 1'b1, u1_d_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int n, input logic drop_p, input logic drop_d,
                             output int stall_n, output int en_n, output int we_n,
                             output logic [W-1:0] a_seen, output logic [W-1:0] wd_seen);
        int got;
        got = 0; stall_n = 0; en_n = 0; we_n = 0; a_seen = '0; wd_seen = '0;
        for (int i = 0; i < 40 && got < n; i++) begin
            @(negedge clk);
            if (p_stall) stall_n++;
            if (dm_en) begin
                en_n++;
                a_seen  = dm_addr;
                wd_seen = dm_wdata;
            end
            if (dm_we) we_n++;
            if (p_ack || d_ack) got++;
            if (got >= n) begin
                p_req = 1'b0;
                d_req = 1'b0;
            end else begin
                if (p_ack && drop_p) p_req = 1'b0;
                if (d_ack && drop_d) d_req = 1'b0;
            end
        end
        chk("ack_count", W'(got), W'(n));
    endtask

    int           s_n, e_n, w_n, pc0;
    logic [W-1:0] a_s, wd_s;

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 64'hCAFE_0000_0000_0000 | W'(i);
        tb_mem[8'h10] = 64'hDEAD;
        tb_mem[8'h30] = 64'hBEEF;
        tb_mem[8'h40] = 64'h1111;
        tb_mem[8'h48] = 64'h2222;

        reset = 1'b1;
        p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        u1_p_req = 1'b0; u1_p_we = 1'b0; u1_p_addr = '0; u1_p_wdata = '0;
        u1_d_req = 1'b0; u1_d_we = 1'b0; u1_d_addr = '0; u1_d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    W'(busy),    W'(0));
        chk("rst_dm_en",   W'(dm_en),   W'(0));
        chk("rst_dm_addr", dm_addr,     '0);
        chk("rst_p_rdata", p_rdata,     '0);
        chk("rst_owner",   W'(owner),   W'(0));
        chk("rst_p_ack",   W'(p_ack),   W'(0));
        reset = 1'b0;
        step();

        // P read, LATENCY 2
        p_req = 1'b1; p_we = 1'b0; p_addr = 64'h10;
        sbq.push_back('{1'b0, 64'hDEAD, cyc + 3});
        wait_acks(1, 1'b1, 1'b0, s_n, e_n, w_n, a_s, wd_s);
        chk("p_stall_cycles", W'(s_n), W'(3));
        chk("p_rd_en_cycles", W'(e_n), W'(2));
        chk("p_rd_we_cycles", W'(w_n), W'(0));
        chk("p_rd_addr",      a_s,     64'h10);
        step(); step();
        chk("p_rdata_hold", p_rdata, 64'hDEAD);
        chk("idle_busy",    W'(busy), W'(0));
        chk("idle_dm_addr", dm_addr,  '0);

        // D read, then D write that must not disturb d_rdata
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h30;
        sbq.push_back('{1'b1, 64'hBEEF, cyc + 3});
        wait_acks(1, 1'b0, 1'b1, s_n, e_n, w_n, a_s, wd_s);
        step();
        chk("owner_d", W'(owner), W'(1));
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h20; d_wdata = 64'h55;
        sbq.push_back('{1'b1, 64'hBEEF, cyc + 3});
        wait_acks(1, 1'b0, 1'b1, s_n, e_n, w_n, a_s, wd_s);
        chk("d_wr_we_cycles", W'(w_n), W'(2));
        chk("d_wr_en_cycles", W'(e_n), W'(2));
        chk("d_wr_addr",      a_s,     64'h20);
        chk("d_wr_wdata",     wd_s,    64'h55);
        step();
        chk("d_rdata_after_wr", d_rdata, 64'hBEEF);
        chk("p_rdata_after_d",  p_rdata, 64'hDEAD);
        d_we = 1'b0;

        // Simultaneous requests: P first, D one occupancy later
        p_req = 1'b1; p_we = 1'b0; p_addr = 64'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h48;
        sbq.push_back('{1'b0, 64'h1111, cyc + 3});
        sbq.push_back('{1'b1, 64'h2222, cyc + 7});
        wait_acks(2, 1'b1, 1'b1, s_n, e_n, w_n, a_s, wd_s);
        step();

        // Both held continuously for three grants
        p_req = 1'b1; d_req = 1'b1;
        sbq.push_back('{1'b0, 64'h1111, cyc + 3});
`ifdef DMEM_ARB_RR_EN
        sbq.push_back('{1'b1, 64'h2222, cyc + 7});
`else
        sbq.push_back('{1'b0, 64'h1111, cyc + 7});
`endif
        sbq.push_back('{1'b0, 64'h1111, cyc + 11});
        wait_acks(3, 1'b0, 1'b0, s_n, e_n, w_n, a_s, wd_s);
        step();
        chk("owner_after_held", W'(owner), W'(0));

        // Reset in the second BUSY cycle of a write
        p_req = 1'b1; p_we = 1'b1; p_addr = 64'h60; p_wdata = 64'h77;
        step(); step();
        chk("mid_wr_dm_we",   W'(dm_we), W'(1));
        chk("mid_wr_dm_addr", dm_addr,   64'h60);
        reset = 1'b1; p_req = 1'b0; p_we = 1'b0;
        #1;
        chk("arst_dm_we",    W'(dm_we), W'(0));
        chk("arst_dm_en",    W'(dm_en), W'(0));
        chk("arst_busy",     W'(busy),  W'(0));
        chk("arst_dm_addr",  dm_addr,   '0);
        chk("arst_dm_wdata", dm_wdata,  '0);
        chk("arst_p_rdata",  p_rdata,   '0);
        chk("arst_d_rdata",  d_rdata,   '0);
        chk("arst_p_ack",    W'(p_ack), W'(0));
        step();
        reset = 1'b0;
        step();

        // P drops its request after one BUSY cycle; the transaction still completes
        pc0 = n_pack;
        p_req = 1'b1; p_we = 1'b0; p_addr = 64'h10;
        sbq.push_back('{1'b0, 64'hDEAD, cyc + 3});
        step(); step();
        p_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("drop_ack_pulses", W'(n_pack - pc0), W'(1));

        // LATENCY 1 instance with early drop
        step();
        u1_p_req = 1'b1; u1_p_we = 1'b0; u1_p_addr = 64'h10;
        sbq1.push_back('{1'b0, 64'hDEAD, cyc + 2});
        step();
        u1_p_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("l1_p_rdata", u1_p_rdata, 64'hDEAD);

        chk("sb_drained",  W'(sbq.size()),  W'(0));
        chk("sb1_drained", W'(sbq1.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
